// File: rtl/rgmii_rx_inband_status_if.sv
// Receive-side GMII bus plus decoded in-band status outputs for rgmii_rx_inband_status.
// master: the PHY-interface/MAC side that drives GMII and reads status.
// slave: the status decoder.
interface rgmii_rx_inband_status_if #(
  parameter int unsigned FC_COUNT_WIDTH = 16
);
  logic [7:0]                gmii_rxd;
  logic                      gmii_rx_dv;
  logic                      gmii_rx_er;
  logic                      fc_clear;
  logic                      link_up;
  logic [1:0]                link_speed;
  logic                      full_duplex;
  logic                      status_valid;
  logic                      status_change;
  logic                      lpi_active;
  logic [FC_COUNT_WIDTH-1:0] fc_count;

  modport master (
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, fc_clear,
    input  link_up, link_speed, full_duplex, status_valid, status_change, lpi_active, fc_count
  );

  modport slave (
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, fc_clear,
    output link_up, link_speed, full_duplex, status_valid, status_change, lpi_active, fc_count
  );
endinterface

// File: rtl/rgmii_rx_inband_status.sv
// RGMII in-band status decoder: qualifies link/speed/duplex nibbles sent during inter-frame
// idle, reports filtered status, LPI and (optionally) a saturating false-carrier count.
// Optional feature macro: RGMII_INBAND_FC_COUNT_EN (false-carrier counter + fc_clear).
module rgmii_rx_inband_status #(
  parameter int unsigned STABLE_COUNT   = 4,
  parameter int unsigned FC_COUNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst_n,
  rgmii_rx_inband_status_if.slave  bus
);

  localparam logic [7:0] StableCnt = 8'(STABLE_COUNT);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e     state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] status_q, status_d;  // {duplex, speed[1:0], link}, same layout as rxd[3:0]
  logic       change_q, change_d;
  logic       lpi_q, lpi_d;

  logic is_status, is_malformed, is_sample, is_lpi, reach;

  // Classify the current bus cycle.
  always_comb begin
    is_status    = !bus.gmii_rx_dv && !bus.gmii_rx_er;
    // A 1G status must repeat its nibble in the upper half; anything else is line noise.
    is_malformed = is_status && (bus.gmii_rxd[2:1] == 2'b10) &&
                   (bus.gmii_rxd[7:4] != bus.gmii_rxd[3:0]);
    is_sample    = is_status && !is_malformed;
    is_lpi       = !bus.gmii_rx_dv && bus.gmii_rx_er && (bus.gmii_rxd == 8'h01);
  end

  // Qualifier: track a candidate nibble and how many valid samples in a row matched it.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    reach  = 1'b0;
    if (is_sample) begin
      if (bus.gmii_rxd[3:0] == cand_q) begin
        if (cnt_q < StableCnt) begin
          cnt_d = 8'(cnt_q + 8'd1);
          reach = (cnt_d == StableCnt);
        end
      end else begin
        cand_d = bus.gmii_rxd[3:0];
        cnt_d  = 8'd1;
        reach  = (StableCnt == 8'd1);
      end
    end
  end

  // Lock FSM and reported-status update.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    change_d = 1'b0;
    lpi_d    = is_lpi;
    unique case (state_q)
      StUnlocked: begin
        // First lock always reports, even if the candidate matches the reset values.
        if (reach) begin
          state_d  = StLocked;
          status_d = cand_d;
          change_d = 1'b1;
        end
      end
      StLocked: begin
        if (reach && (cand_d != status_q)) begin
          status_d = cand_d;
          change_d = 1'b1;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  // Qualifier, FSM and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StUnlocked;
      cand_q   <= 4'h0;
      cnt_q    <= 8'd0;
      status_q <= 4'h0;
      change_q <= 1'b0;
      lpi_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      change_q <= change_d;
      lpi_q    <= lpi_d;
    end
  end

  assign bus.link_up       = status_q[0];
  assign bus.link_speed    = status_q[2:1];
  assign bus.full_duplex   = status_q[3];
  assign bus.status_valid  = (state_q == StLocked);
  assign bus.status_change = change_q;
  assign bus.lpi_active    = lpi_q;

`ifdef RGMII_INBAND_FC_COUNT_EN
  logic                      is_fc;
  logic [FC_COUNT_WIDTH-1:0] fc_q, fc_d;

  // False-carrier counter: saturating, clear wins over the old value but not the new event.
  always_comb begin
    is_fc = !bus.gmii_rx_dv && bus.gmii_rx_er && (bus.gmii_rxd[3:0] == 4'hE);
    fc_d  = fc_q;
    if (bus.fc_clear) begin
      fc_d = is_fc ? FC_COUNT_WIDTH'(1) : '0;
    end else if (is_fc && (fc_q != '1)) begin
      fc_d = FC_COUNT_WIDTH'(fc_q + FC_COUNT_WIDTH'(1));
    end
  end

  // False-carrier count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_q <= '0;
    end else begin
      fc_q <= fc_d;
    end
  end

  assign bus.fc_count = fc_q;
`else
  logic unused_fc_clear;
  assign unused_fc_clear = bus.fc_clear;
  assign bus.fc_count    = {FC_COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rgmii_rx_inband_status.sv
// Self-checking bench for rgmii_rx_inband_status (STABLE_COUNT=4, FC_COUNT_WIDTH=4).
module tb_rgmii_rx_inband_status;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgmii_rx_inband_status_if #(.FC_COUNT_WIDTH(4)) bus ();

  rgmii_rx_inband_status #(
    .STABLE_COUNT  (4),
    .FC_COUNT_WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic       link;
    logic [1:0] speed;
    logic       duplex;
    logic       valid;
    logic       change;
    logic       lpi;
    logic [3:0] fc;
  } obs_t;

  obs_t exp_q[$];
  obs_t cur;
  int   n_chk = 0;
  int   n_pass = 0;

  function automatic obs_t obs();
    obs_t o;
    o.link   = bus.link_up;
    o.speed  = bus.link_speed;
    o.duplex = bus.full_duplex;
    o.valid  = bus.status_valid;
    o.change = bus.status_change;
    o.lpi    = bus.lpi_active;
    o.fc     = bus.fc_count;
    return o;
  endfunction

  task automatic step(input logic [7:0] d, input logic dv, input logic er, input logic clr);
    bus.gmii_rxd   = d;
    bus.gmii_rx_dv = dv;
    bus.gmii_rx_er = er;
    bus.fc_clear   = clr;
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between clock edges and check the asynchronous clear.
  task automatic test_reset(input string tag);
    obs_t got, want;
    rst_n = 1'b0;
    #2;
    cur = '0;
    exp_q.push_back(cur);
    want = exp_q.pop_front();
    got  = obs();
    n_chk++;
    if (got !== want) $display("FAIL reset_%s got=%h want=%h", tag, got, want);
    else n_pass++;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_lock_1g();
    obs_t got, want;
    for (int i = 0; i < 4; i++) begin
      cur.change = (i == 3);
      if (i == 3) begin
        cur.link = 1'b1; cur.speed = 2'b10; cur.duplex = 1'b1; cur.valid = 1'b1;
      end
      exp_q.push_back(cur);
      step(8'hDD, 1'b0, 1'b0, 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL lock_1g[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
    cur.change = 1'b0;
    exp_q.push_back(cur);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    want = exp_q.pop_front();
    got  = obs();
    n_chk++;
    if (got !== want) $display("FAIL lock_1g_pulse_end got=%h want=%h", got, want);
    else n_pass++;
  endtask

  // 8'hCC = link down, 1G, full duplex (a well-formed 1G sample).
  task automatic test_status_change();
    logic [7:0] seq [9];
    obs_t got, want;
    seq = '{8'hCC, 8'hCC, 8'hCC, 8'hDD, 8'hCC, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
    for (int i = 0; i < 9; i++) begin
      cur.change = (i == 7);
      if (i == 7) cur.link = 1'b0;
      exp_q.push_back(cur);
      step(seq[i], 1'b0, 1'b0, 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL status_change[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
    cur.change = 1'b0;
  endtask

  task automatic test_lpi();
    logic [7:0] d   [4];
    logic       dv  [4];
    logic       exl [4];
    obs_t got, want;
    d   = '{8'h01, 8'h55, 8'h01, 8'h11};
    dv  = '{1'b0, 1'b1, 1'b0, 1'b0};
    exl = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cur.lpi = exl[i];
      exp_q.push_back(cur);
      step(d[i], dv[i], 1'b1, 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL lpi[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
    cur.lpi = 1'b0;
  endtask

  task automatic test_false_carrier();
    obs_t got, want;
`ifdef RGMII_INBAND_FC_COUNT_EN
    for (int i = 0; i < 3; i++) begin
      cur.fc = 4'(i + 1);
      exp_q.push_back(cur);
      step((i == 1) ? 8'hAE : 8'h0E, 1'b0, 1'b1, 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL fc_count[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
    cur.fc = 4'd1;
    exp_q.push_back(cur);
    step(8'h0E, 1'b0, 1'b1, 1'b1);
    want = exp_q.pop_front();
    got  = obs();
    n_chk++;
    if (got !== want) $display("FAIL fc_clear_with_event got=%h want=%h", got, want);
    else n_pass++;
    cur.fc = 4'd0;
    exp_q.push_back(cur);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    want = exp_q.pop_front();
    got  = obs();
    n_chk++;
    if (got !== want) $display("FAIL fc_clear got=%h want=%h", got, want);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cur.fc = (i >= 14) ? 4'd15 : 4'(i + 1);
      exp_q.push_back(cur);
      step(8'h0E, 1'b0, 1'b1, 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL fc_saturate[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
`else
    for (int i = 0; i < 4; i++) begin
      cur.fc = 4'd0;
      exp_q.push_back(cur);
      step(8'h0E, 1'b0, 1'b1, (i == 2));
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL fc_disabled[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
`endif
  endtask

  // Reset after 3 of 4 samples must discard the run.
  task automatic test_reset_mid();
    obs_t got, want;
    test_reset("pre_mid");
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(cur);
        step(8'hDD, 1'b0, 1'b0, 1'b0);
        want = exp_q.pop_front();
        got  = obs();
        n_chk++;
        if (got !== want) $display("FAIL reset_mid_run%0d[%0d] got=%h want=%h", r, i, got, want);
        else n_pass++;
      end
      if (r == 0) test_reset("mid_qual");
    end
    cur.link = 1'b1; cur.speed = 2'b10; cur.duplex = 1'b1; cur.valid = 1'b1; cur.change = 1'b1;
    exp_q.push_back(cur);
    step(8'hDD, 1'b0, 1'b0, 1'b0);
    want = exp_q.pop_front();
    got  = obs();
    n_chk++;
    if (got !== want) $display("FAIL reset_mid_lock got=%h want=%h", got, want);
    else n_pass++;
    cur.change = 1'b0;
  endtask

  // Frame data and carrier-extend cycles between samples only stretch qualification.
  task automatic test_neutral_stretch();
    obs_t got, want;
    test_reset("pre_stretch");
    for (int i = 0; i < 104; i++) begin
      if (i == 103) begin
        cur.link = 1'b1; cur.speed = 2'b01; cur.duplex = 1'b1; cur.valid = 1'b1;
        cur.change = 1'b1;
      end
      exp_q.push_back(cur);
      if (i < 2 || i >= 102) step(8'h0B, 1'b0, 1'b0, 1'b0);
      else if (i % 17 == 0) step(8'h0F, 1'b0, 1'b1, 1'b0);
      else step(8'($urandom), 1'b1, 1'($urandom), 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL stretch[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
    cur.change = 1'b0;
  endtask

  // Malformed 1G samples (upper nibble mismatch) are ignored while locked at 100M.
  task automatic test_malformed();
    obs_t got, want;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(cur);
      if (i < 6) step(8'h5D, 1'b0, 1'b0, 1'b0);
      else if (i < 10) step(8'h0C, 1'b0, 1'b0, 1'b0);
      else step(8'h0B, 1'b0, 1'b0, 1'b0);
      want = exp_q.pop_front();
      got  = obs();
      n_chk++;
      if (got !== want) $display("FAIL malformed[%0d] got=%h want=%h", i, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.gmii_rxd   = 8'h00;
    bus.gmii_rx_dv = 1'b1;
    bus.gmii_rx_er = 1'b0;
    bus.fc_clear   = 1'b0;
    cur            = '0;
    @(posedge clk);
    #1;
    test_reset("initial");
    test_lock_1g();
    test_status_change();
    test_lpi();
    test_false_carrier();
    test_reset_mid();
    test_neutral_stretch();
    test_malformed();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
